pipeline_hazard_ctrl: RTL
=========================

// Module: pipeline_hazard_ctrl
// PURPOSE
//  Sequencer for the 5-stage MIPS pipeline: stalls, bubbles and flushes driven by load-use
//  hazards, taken branches/jumps and data-memory wait states. Sits beside the opcode decoder.
//  Consumes decoded MemRead/Branch/Jump qualifiers from ID/EX and EX; drives PC and
//  pipeline-register enables.
// PARAMETERS
//  LOAD_USE_STALLS  1    bubbles per load-use hazard (1 = forwarding present, 2 = none)
//  BR_FLUSH_CYCLES  2    younger stages squashed on taken branch resolved in EX (1..3)
//  MEM_TIMEOUT      255  max dmem wait cycles before mem_timeout_err; 8-bit counter
// PORTS
//  clk              in   1  system clock, rising edge
//  reset            in   1  synchronous, active-high
//  ifid_rs          in   5  rs of instruction in IF/ID
//  ifid_rt          in   5  rt of instruction in IF/ID
//  ifid_uses_rt     in   1  IF/ID instruction reads rt (R-type, SW, BEQ, BNE)
//  idex_mem_read    in   1  MemRead of instruction in ID/EX
//  idex_rt          in   5  destination rt of load in ID/EX
//  id_jump          in   1  J/JAL decoded in ID
//  ex_branch_taken  in   1  BEQ/BNE resolved taken in EX
//  dmem_req         in   1  MEM stage access (MemRead|MemWrite)
//  dmem_ready       in   1  data memory completes access this cycle
//  pc_write         out  1  PC update enable
//  ifid_write       out  1  IF/ID load enable
//  ifid_flush       out  1  IF/ID synchronous clear to NOP
//  idex_bubble      out  1  ID/EX loads all-zero control word
//  exmem_write      out  1  EX/MEM and MEM/WB load enable
//  mem_timeout_err  out  1  sticky error, cleared only by reset
// BEHAVIOUR
//  - Registered state: state (RUN, LU_STALL, MEM_WAIT, FLUSH), cnt[7:0], mem_timeout_err.
//    Other outputs are combinational from state and inputs.
//  - While reset=1: pc_write=0, ifid_write=0, ifid_flush=1, idex_bubble=1, exmem_write=0.
//    Next edge: state=RUN, cnt=0, mem_timeout_err=0.
//  - hazard = idex_mem_read & idex_rt!=0 & (idex_rt==ifid_rs | (ifid_uses_rt & idex_rt==ifid_rt)).
//  - Priority per cycle: MEM_WAIT > ex_branch_taken > hazard > id_jump.
//  - RUN: all enables 1, flush/bubble 0, unless:
//    - dmem_req & !dmem_ready: freeze all (pc/ifid/exmem write 0, no flush) -> MEM_WAIT, cnt=0.
//    - ex_branch_taken: ifid_flush=1, idex_bubble=1, pc_write=1 (target);
//      BR_FLUSH_CYCLES>1 -> FLUSH, cnt=BR_FLUSH_CYCLES-2.
//    - hazard: pc_write=0, ifid_write=0, idex_bubble=1;
//      LOAD_USE_STALLS>1 -> LU_STALL, cnt=LOAD_USE_STALLS-2.
//    - id_jump: ifid_flush=1 only (one slot).
//  - LU_STALL: same outputs as hazard; cnt==0 -> RUN, else cnt-1. A taken branch preempts -> RUN
//    with branch outputs.
//  - FLUSH: ifid_flush=1, idex_bubble=1, pc_write=1; cnt==0 -> RUN, else cnt-1.
//  - MEM_WAIT: all frozen; dmem_ready -> RUN. Otherwise cnt+1. cnt==MEM_TIMEOUT -> set
//    mem_timeout_err, force RUN (drop access). cnt saturates, no wrap.
//  - Branch and jump in same cycle: branch wins (the jump is younger).
//  - Hazard and branch in same cycle: branch wins; the load still completes.
//  - Reset mid-MEM_WAIT or mid-FLUSH: abort immediately to reset values; no residual count.
// CONFIGURATION
//  HAZARD_PERF_CNT_EN defined:
//    - Add out ports stall_count[31:0] and flush_count[31:0], both reset 0, wrapping.
//    - stall_count += 1 each cycle pc_write=0.
//    - flush_count += 1 each cycle ifid_flush=1 outside reset.
//  Undefined: ports and logic absent; core behaviour identical.
// STRUCTURE
//  - Package mips_hazard_pkg: state encoding localparams (RUN=2'd0, LU_STALL=2'd1,
//    MEM_WAIT=2'd2, FLUSH=2'd3), REG_ZERO=5'd0, CNT_W=8.
//  - Sub-module load_use_detect: purely combinational hazard compare, instantiated once.
// TESTING
//  1. LW $t0 then ADD using $t0 as rs, LOAD_USE_STALLS=1 -> one cycle pc_write=0,
//     idex_bubble=1, then RUN.
//  2. Same with idex_rt=0 -> no stall; ifid_uses_rt=0 with rt match only -> no stall.
//  3. ex_branch_taken pulse, BR_FLUSH_CYCLES=2 -> ifid_flush=1 and idex_bubble=1 for exactly
//     2 cycles.
//  4. dmem_req=1, dmem_ready low 3 cycles -> all enables 0 for 3 cycles, resume on 4th.
//     Hold low 256 cycles -> mem_timeout_err=1, sticky.
//  5. Same-cycle hazard+branch and branch+jump -> branch response only. Reset in MEM_WAIT
//     -> state RUN next cycle.
//  6. HAZARD_PERF_CNT_EN: scenarios 1+3 -> stall_count=1, flush_count=2.

Source files
------------

// File: rtl/mips_hazard_pkg.sv
// Shared types for the MIPS pipeline hazard sequencer.
// State encodings, register constants and the control-word bundle.
package mips_hazard_pkg;

    localparam int CNT_W = 8;
    localparam logic [4:0] REG_ZERO = 5'd0;

    localparam logic [1:0] RUN      = 2'd0;
    localparam logic [1:0] LU_STALL = 2'd1;
    localparam logic [1:0] MEM_WAIT = 2'd2;
    localparam logic [1:0] FLUSH    = 2'd3;

    typedef enum logic [1:0] {
        StRun     = RUN,
        StLuStall = LU_STALL,
        StMemWait = MEM_WAIT,
        StFlush   = FLUSH
    } state_e;

    typedef struct packed {
        logic pcWrite;
        logic ifidWrite;
        logic ifidFlush;
        logic idexBubble;
        logic exmemWrite;
    } ctrl_t;

    localparam ctrl_t CTRL_RUN    = 5'b11001;
    localparam ctrl_t CTRL_FREEZE = 5'b00000;
    localparam ctrl_t CTRL_BRANCH = 5'b11111;
    localparam ctrl_t CTRL_HAZARD = 5'b00011;
    localparam ctrl_t CTRL_JUMP   = 5'b11101;
    localparam ctrl_t CTRL_RESET  = 5'b00110;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Decoder-side qualifiers in, pipeline enables out.
// HAZARD_PERF_CNT_EN adds stall_count/flush_count.
interface pipeline_hazard_ctrl_if;
    logic [4:0]  ifid_rs;
    logic [4:0]  ifid_rt;
    logic        ifid_uses_rt;
    logic        idex_mem_read;
    logic [4:0]  idex_rt;
    logic        id_jump;
    logic        ex_branch_taken;
    logic        dmem_req;
    logic        dmem_ready;
    logic        pc_write;
    logic        ifid_write;
    logic        ifid_flush;
    logic        idex_bubble;
    logic        exmem_write;
    logic        mem_timeout_err;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_count;
    logic [31:0] flush_count;

    modport master (
        output ifid_rs, ifid_rt, ifid_uses_rt, idex_mem_read, idex_rt,
        output id_jump, ex_branch_taken, dmem_req, dmem_ready,
        input  pc_write, ifid_write, ifid_flush, idex_bubble, exmem_write,
        input  mem_timeout_err, stall_count, flush_count
    );
    modport slave (
        input  ifid_rs, ifid_rt, ifid_uses_rt, idex_mem_read, idex_rt,
        input  id_jump, ex_branch_taken, dmem_req, dmem_ready,
        output pc_write, ifid_write, ifid_flush, idex_bubble, exmem_write,
        output mem_timeout_err, stall_count, flush_count
    );
`else
    modport master (
        output ifid_rs, ifid_rt, ifid_uses_rt, idex_mem_read, idex_rt,
        output id_jump, ex_branch_taken, dmem_req, dmem_ready,
        input  pc_write, ifid_write, ifid_flush, idex_bubble, exmem_write,
        input  mem_timeout_err
    );
    modport slave (
        input  ifid_rs, ifid_rt, ifid_uses_rt, idex_mem_read, idex_rt,
        input  id_jump, ex_branch_taken, dmem_req, dmem_ready,
        output pc_write, ifid_write, ifid_flush, idex_bubble, exmem_write,
        output mem_timeout_err
    );
`endif
endinterface

// File: rtl/load_use_detect.sv
// Combinational load-use compare between ID/EX load and IF/ID sources.
// Writes to $zero never create a dependency.
module load_use_detect
    import mips_hazard_pkg::*;
(
    input  logic [4:0] ifidRs,
    input  logic [4:0] ifidRt,
    input  logic       ifidUsesRt,
    input  logic       idexMemRead,
    input  logic [4:0] idexRt,
    output logic       hazard
);
    logic rsHit;
    logic rtHit;

    assign rsHit  = (idexRt == ifidRs);
    assign rtHit  = ifidUsesRt & (idexRt == ifidRt);
    assign hazard = idexMemRead & (idexRt != REG_ZERO) & (rsHit | rtHit);
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/bubble/flush sequencer for the 5-stage MIPS pipeline.
// Optional HAZARD_PERF_CNT_EN adds stall/flush performance counters.
module pipeline_hazard_ctrl
    import mips_hazard_pkg::*;
#(
    parameter int LOAD_USE_STALLS = 1,
    parameter int BR_FLUSH_CYCLES = 2,
    parameter int MEM_TIMEOUT     = 255
) (
    input  logic                   clk,
    input  logic                   reset,
    pipeline_hazard_ctrl_if.slave  hz
);
    state_e           state;
    state_e           stateNxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cntNxt;
    logic             timeoutErr;
    logic             errNxt;
    logic             hazard;
    logic             memStall;
    logic             runLike;
    ctrl_t            ctrl;

    load_use_detect u_lud (
        .ifidRs      (hz.ifid_rs),
        .ifidRt      (hz.ifid_rt),
        .ifidUsesRt  (hz.ifid_uses_rt),
        .idexMemRead (hz.idex_mem_read),
        .idexRt      (hz.idex_rt),
        .hazard      (hazard)
    );

    assign memStall = hz.dmem_req & ~hz.dmem_ready;
    // A completing wait cycle advances the pipe exactly like RUN.
    assign runLike  = (state == StRun) |
                      ((state == StMemWait) & hz.dmem_ready);

    always_comb begin
        stateNxt = state;
        cntNxt   = cnt;
        errNxt   = timeoutErr;
        ctrl     = CTRL_RUN;
        if (runLike) begin
            stateNxt = StRun;
            priority case (1'b1)
                memStall: begin
                    ctrl     = CTRL_FREEZE;
                    stateNxt = StMemWait;
                    cntNxt   = '0;
                end
                hz.ex_branch_taken: begin
                    ctrl = CTRL_BRANCH;
                    if (BR_FLUSH_CYCLES > 1) begin
                        stateNxt = StFlush;
                        cntNxt   = CNT_W'(BR_FLUSH_CYCLES - 2);
                    end
                end
                hazard: begin
                    ctrl = CTRL_HAZARD;
                    if (LOAD_USE_STALLS > 1) begin
                        stateNxt = StLuStall;
                        cntNxt   = CNT_W'(LOAD_USE_STALLS - 2);
                    end
                end
                hz.id_jump: ctrl = CTRL_JUMP;
                default: ;
            endcase
        end else begin
            case (state)
                StLuStall: begin
                    if (hz.ex_branch_taken) begin
                        ctrl     = CTRL_BRANCH;
                        stateNxt = StRun;
                    end else begin
                        ctrl = CTRL_HAZARD;
                        if (cnt == '0) stateNxt = StRun;
                        else           cntNxt   = cnt - 1'b1;
                    end
                end
                StFlush: begin
                    ctrl = CTRL_BRANCH;
                    if (cnt == '0) stateNxt = StRun;
                    else           cntNxt   = cnt - 1'b1;
                end
                StMemWait: begin
                    ctrl = CTRL_FREEZE;
                    if (cnt == CNT_W'(MEM_TIMEOUT)) begin
                        errNxt   = 1'b1;
                        stateNxt = StRun;
                    end else if (cnt != '1) begin
                        cntNxt = cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
        if (reset) ctrl = CTRL_RESET;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= StRun;
            cnt        <= '0;
            timeoutErr <= 1'b0;
        end else begin
            state      <= stateNxt;
            cnt        <= cntNxt;
            timeoutErr <= errNxt;
        end
    end

    assign hz.pc_write        = ctrl.pcWrite;
    assign hz.ifid_write      = ctrl.ifidWrite;
    assign hz.ifid_flush      = ctrl.ifidFlush;
    assign hz.idex_bubble     = ctrl.idexBubble;
    assign hz.exmem_write     = ctrl.exmemWrite;
    assign hz.mem_timeout_err = timeoutErr;

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stallCount;
    logic [31:0] flushCount;

    always_ff @(posedge clk) begin
        if (reset) begin
            stallCount <= '0;
            flushCount <= '0;
        end else begin
            if (!ctrl.pcWrite)  stallCount <= stallCount + 1'b1;
            if (ctrl.ifidFlush) flushCount <= flushCount + 1'b1;
        end
    end

    assign hz.stall_count = stallCount;
    assign hz.flush_count = flushCount;
`endif
endmodule
